// File: rtl/sccb_pkg.sv
// Shared SCCB definitions used by the responder and the camera init path.
package sccb_pkg;

   // Frame geometry: 8 data bits followed by one ACK/NA slot
   localparam int unsigned SCCB_BITS_PER_PHASE = 9;

   // Default OV7670 device addresses (write / read)
   localparam logic [7:0] OV7670_WR_ID = 8'h42;
   localparam logic [7:0] OV7670_RD_ID = 8'h43;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_IGNORE
   } sccb_state_t;

   // Bit counter advance with wrap at the end of the 9-bit frame
   function automatic logic [3:0] bit_next(input logic [3:0] cnt);
      return (cnt >= 4'(SCCB_BITS_PER_PHASE - 1)) ? 4'd0 : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises sioc/siod and derives clock edges and START/STOP conditions.
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sioc,
   input  logic siod,
   output logic sioc_rise,
   output logic sioc_fall,
   output logic start,
   output logic stop,
   output logic siod_lvl
);

   logic [SYNC_STAGES-1:0] sioc_sync;
   logic [SYNC_STAGES-1:0] siod_sync;
   logic                   sioc_prev;
   logic                   siod_prev;
   logic                   sioc_s;

   // Synchroniser chains plus one history flop per line for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sioc_sync <= '1;
         siod_sync <= '1;
         sioc_prev <= 1'b1;
         siod_prev <= 1'b1;
      end else begin
         sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
         siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
         sioc_prev <= sioc_sync[SYNC_STAGES-1];
         siod_prev <= siod_sync[SYNC_STAGES-1];
      end
   end

   // Edge and bus-condition pulses from the last two synced samples
   always_comb begin
      sioc_s    = sioc_sync[SYNC_STAGES-1];
      siod_lvl  = siod_sync[SYNC_STAGES-1];
      sioc_rise = sioc_s & ~sioc_prev;
      sioc_fall = ~sioc_s & sioc_prev;
      start     = sioc_s & sioc_prev & siod_prev & ~siod_lvl;
      stop      = sioc_s & sioc_prev & ~siod_prev & siod_lvl;
   end

endmodule

// File: rtl/sccb_responder.sv
// SCCB target emulating the OV7670 register interface (3-phase write, 2-phase read).
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [7:0]  DEV_ID      = OV7670_WR_ID,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACK_EN      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sioc,
   input  logic       siod_i,
   output logic       siod_oe,
   output logic [7:0] reg_addr,
   output logic       wr_en,
   output logic [7:0] wr_data,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       id_err
);

   localparam logic [7:0] RD_ID    = DEV_ID | 8'h01;
   localparam logic       ACK_LVL  = (ACK_EN != 0);
   localparam logic [3:0] LAST_BIT = 4'(SCCB_BITS_PER_PHASE - 1);

   logic        sioc_rise;
   logic        sioc_fall;
   logic        start_evt;
   logic        stop_evt;
   logic        siod_lvl;

   sccb_state_t state;
   sccb_state_t nxt_state;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        in_ack;
   logic        inc_pend;
   logic [7:0]  byte_in;

   sccb_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .sioc     (sioc),
      .siod     (siod_i),
      .sioc_rise(sioc_rise),
      .sioc_fall(sioc_fall),
      .start    (start_evt),
      .stop     (stop_evt),
      .siod_lvl (siod_lvl)
   );

   // Byte as it will look once the current sample is shifted in
   always_comb begin
      byte_in = {shreg[6:0], siod_lvl};
   end

   // Protocol FSM: START/STOP override, sample on sioc rise, drive on sioc fall.
   // A decoded byte only arms in_ack/nxt_state; the phase change and any
   // reg_addr increment are deferred to the falling edge that closes the ACK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         nxt_state <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         in_ack    <= 1'b0;
         inc_pend  <= 1'b0;
         siod_oe   <= 1'b0;
         reg_addr  <= '0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         busy      <= 1'b0;
         id_err    <= 1'b0;
      end else begin
         wr_en  <= 1'b0;
         id_err <= 1'b0;
         if (start_evt) begin
            state    <= ST_ID;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            siod_oe  <= 1'b0;
            in_ack   <= 1'b0;
            inc_pend <= 1'b0;
         end else if (stop_evt) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            siod_oe  <= 1'b0;
            in_ack   <= 1'b0;
            inc_pend <= 1'b0;
         end else if (sioc_rise) begin
            bit_cnt <= bit_next(bit_cnt);
            if (bit_cnt < LAST_BIT && state != ST_RDATA) begin
               shreg <= byte_in;
            end
            if (bit_cnt == LAST_BIT - 4'd1) begin
               case (state)
                  ST_ID: begin
                     if (byte_in == DEV_ID) begin
                        in_ack    <= 1'b1;
                        nxt_state <= ST_ADDR;
                     end else if (byte_in == RD_ID) begin
                        in_ack    <= 1'b1;
                        nxt_state <= ST_RDATA;
                     end else begin
                        id_err <= 1'b1;
                        state  <= ST_IGNORE;
                     end
                  end
                  ST_ADDR: begin
                     reg_addr  <= byte_in;
                     in_ack    <= 1'b1;
                     nxt_state <= ST_WDATA;
                  end
                  ST_WDATA: begin
                     wr_data   <= byte_in;
                     wr_en     <= 1'b1;
                     in_ack    <= 1'b1;
                     inc_pend  <= 1'b1;
                     nxt_state <= ST_WDATA;
                  end
                  default: ;
               endcase
            end
            if (bit_cnt == LAST_BIT && state == ST_RDATA) begin
               reg_addr <= reg_addr + 8'd1;
               state    <= ST_IGNORE;
            end
         end else if (sioc_fall) begin
            if (in_ack) begin
               if (bit_cnt == LAST_BIT) begin
                  siod_oe <= ACK_LVL;
               end else if (bit_cnt == 4'd0) begin
                  in_ack   <= 1'b0;
                  inc_pend <= 1'b0;
                  state    <= nxt_state;
                  if (inc_pend) begin
                     reg_addr <= reg_addr + 8'd1;
                  end
                  if (nxt_state == ST_RDATA) begin
                     shreg   <= rd_data;
                     siod_oe <= ~rd_data[7];
                  end else begin
                     siod_oe <= 1'b0;
                  end
               end
            end else if (state == ST_RDATA && bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
               shreg   <= {shreg[6:0], 1'b0};
               siod_oe <= ~shreg[6];
            end else begin
               siod_oe <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master with an open-drain bus.
module tb_sccb_responder;
   import sccb_pkg::*;

   localparam int Q = 8;  // clk cycles per sioc quarter/half phase

   logic       clk = 1'b0;
   logic       reset;
   logic       sioc_m;
   logic       sda_m;
   logic       siod_i;
   logic       siod_oe;
   logic [7:0] reg_addr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       busy;
   logic       id_err;

   assign siod_i = sda_m & ~siod_oe;

   always #5 clk = ~clk;

   sccb_responder #(
      .DEV_ID     (8'h42),
      .SYNC_STAGES(2),
      .ACK_EN     (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sioc    (sioc_m),
      .siod_i  (siod_i),
      .siod_oe (siod_oe),
      .reg_addr(reg_addr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .busy    (busy),
      .id_err  (id_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] wr_a_q[$];
   logic [7:0] wr_d_q[$];
   int         id_err_cnt = 0;
   int         oe_cnt     = 0;

   // Passive monitor of strobes and bus drive
   always @(negedge clk) begin
      if (wr_en) begin
         wr_a_q.push_back(reg_addr);
         wr_d_q.push_back(wr_data);
      end
      if (id_err) id_err_cnt++;
      if (siod_oe) oe_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bit(input logic b, output logic seen);
      sda_m = b;
      wait_clk(Q);
      sioc_m = 1'b1;
      wait_clk(Q / 2);
      seen = siod_i;
      wait_clk(Q / 2);
      sioc_m = 1'b0;
      wait_clk(2);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
      xfer_bit(1'b1, s);
      ack = ~s;
      wait_clk(Q);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d, output logic slot9);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, s);
         d[i] = s;
      end
      xfer_bit(nack, slot9);
      wait_clk(Q);
   endtask

   task automatic start_cond();
      sda_m = 1'b1;
      wait_clk(Q);
      sioc_m = 1'b1;
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      sioc_m = 1'b0;
      wait_clk(Q);
   endtask

   task automatic stop_cond();
      sda_m = 1'b0;
      wait_clk(Q);
      sioc_m = 1'b1;
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
   endtask

   typedef struct packed {
      logic [2:0]  nb;
      logic [31:0] bytes;
      logic [3:0]  ack_exp;
      logic [1:0]  wr_n;
      logic [7:0]  wa0, wd0, wa1, wd1;
      logic [1:0]  ide;
      logic [7:0]  ra_exp;
   } vec_t;

   function automatic vec_t mk(input int nb, input logic [31:0] bytes, input logic [3:0] ack,
                               input int wr_n, input logic [7:0] wa0, input logic [7:0] wd0,
                               input logic [7:0] wa1, input logic [7:0] wd1,
                               input int ide, input logic [7:0] ra);
      vec_t v;
      v.nb = 3'(nb); v.bytes = bytes; v.ack_exp = ack; v.wr_n = 2'(wr_n);
      v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.ide = 2'(ide); v.ra_exp = ra;
      return v;
   endfunction

   initial begin
      vec_t       tbl[6];
      vec_t       tv;
      logic       ack;
      logic       slot9;
      logic [7:0] rbyte;
      int         wr0, id0, oe0;

      // Byte i of a vector lives in bytes[31-8i -: 8]; ack_exp bit i belongs to byte i
      tbl[0] = mk(3, 32'h42_12_80_00, 4'b0111, 1, 8'h12, 8'h80, 8'h00, 8'h00, 0, 8'h13);
      tbl[1] = mk(3, 32'h60_AA_BB_00, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h13);
      tbl[2] = mk(4, 32'h42_FF_11_22, 4'b1111, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 0, 8'h01);
      tbl[3] = mk(2, 32'h42_05_00_00, 4'b0011, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h05);
      tbl[4] = mk(1, 32'h42_00_00_00, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h05);
      tbl[5] = mk(2, 32'h42_0A_00_00, 4'b0011, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h0A);

      reset   = 1'b1;
      sioc_m  = 1'b1;
      sda_m   = 1'b1;
      rd_data = 8'h76;
      wait_clk(3);
      check("rst siod_oe", siod_oe, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst reg_addr", reg_addr, 8'h00);
      check("rst wr_en", wr_en, 1'b0);
      check("rst wr_data", wr_data, 8'h00);
      check("rst id_err", id_err, 1'b0);
      reset = 1'b0;
      wait_clk(5);

      // Table-driven complete transactions
      for (int v = 0; v < 6; v++) begin
         tv  = tbl[v];
         wr0 = wr_a_q.size();
         id0 = id_err_cnt;
         oe0 = oe_cnt;
         start_cond();
         check($sformatf("v%0d busy after start", v), busy, 1'b1);
         for (int i = 0; i < int'(tv.nb); i++) begin
            send_byte(tv.bytes[31 - 8 * i -: 8], ack);
            check($sformatf("v%0d ack byte%0d", v, i), ack, tv.ack_exp[i]);
         end
         stop_cond();
         wait_clk(4);
         check($sformatf("v%0d busy after stop", v), busy, 1'b0);
         check($sformatf("v%0d wr_en count", v), wr_a_q.size() - wr0, tv.wr_n);
         if (tv.wr_n >= 1 && wr_a_q.size() > wr0) begin
            check($sformatf("v%0d wr0 addr", v), wr_a_q[wr0], tv.wa0);
            check($sformatf("v%0d wr0 data", v), wr_d_q[wr0], tv.wd0);
         end
         if (tv.wr_n >= 2 && wr_a_q.size() > wr0 + 1) begin
            check($sformatf("v%0d wr1 addr", v), wr_a_q[wr0 + 1], tv.wa1);
            check($sformatf("v%0d wr1 data", v), wr_d_q[wr0 + 1], tv.wd1);
         end
         check($sformatf("v%0d id_err pulses", v), id_err_cnt - id0, tv.ide);
         check($sformatf("v%0d siod driven", v), (oe_cnt != oe0), (tv.ack_exp != 4'b0000));
         check($sformatf("v%0d reg_addr", v), reg_addr, tv.ra_exp);
      end

      // Read from 0x0A (pointer left there by the last vector), data 0x76
      wr0 = wr_a_q.size();
      start_cond();
      send_byte(8'h43, ack);
      check("rd id ack", ack, 1'b1);
      read_byte(1'b1, rbyte, slot9);
      check("rd data", rbyte, 8'h76);
      check("rd slot9 released", slot9, 1'b1);
      stop_cond();
      wait_clk(4);
      check("rd reg_addr", reg_addr, 8'h0B);
      check("rd no wr_en", wr_a_q.size() - wr0, 0);
      check("rd busy after stop", busy, 1'b0);

      // Repeated START abandons 42/05; the following 42/06/33 writes once
      wr0 = wr_a_q.size();
      start_cond();
      send_byte(8'h42, ack);
      send_byte(8'h05, ack);
      start_cond();
      check("rs busy", busy, 1'b1);
      send_byte(8'h42, ack);
      check("rs id ack", ack, 1'b1);
      send_byte(8'h06, ack);
      send_byte(8'h33, ack);
      check("rs data ack", ack, 1'b1);
      stop_cond();
      wait_clk(4);
      check("rs wr_en count", wr_a_q.size() - wr0, 1);
      if (wr_a_q.size() > wr0) begin
         check("rs wr addr", wr_a_q[wr0], 8'h06);
         check("rs wr data", wr_d_q[wr0], 8'h33);
      end
      check("rs reg_addr", reg_addr, 8'h07);

      // Reset while ACK is being driven
      begin
         logic s;
         start_cond();
         for (int i = 7; i >= 0; i--) xfer_bit(OV7670_WR_ID[i], s);
         wait_clk(4);
         check("mid ack siod_oe", siod_oe, 1'b1);
         check("mid ack busy", busy, 1'b1);
         @(negedge clk);
         reset = 1'b1;
         #1;
         check("async rst siod_oe", siod_oe, 1'b0);
         check("async rst busy", busy, 1'b0);
         check("async rst reg_addr", reg_addr, 8'h00);
         sioc_m = 1'b1;
         sda_m  = 1'b1;
         wait_clk(4);
         reset = 1'b0;
         wait_clk(5);
      end

      wr0 = wr_a_q.size();
      start_cond();
      send_byte(8'h42, ack);
      check("post rst id ack", ack, 1'b1);
      send_byte(8'h01, ack);
      send_byte(8'h55, ack);
      check("post rst data ack", ack, 1'b1);
      stop_cond();
      wait_clk(4);
      check("post rst wr_en count", wr_a_q.size() - wr0, 1);
      if (wr_a_q.size() > wr0) begin
         check("post rst wr addr", wr_a_q[wr0], 8'h01);
         check("post rst wr data", wr_d_q[wr0], 8'h55);
      end
      check("post rst reg_addr", reg_addr, 8'h02);
      check("post rst busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
SCCB (I2C-style) target that decodes the 3-phase write and 2-phase read transactions the camera init path issues. It emulates the OV7670 register interface for simulation and for FPGA-to-FPGA loopback of the init sequence. It oversamples sioc/siod on the core clock, matches the device ID, and drives ACK and read data on an open-drain siod. It exposes a byte-wide register write/read port.

Parameters:
DEV_ID, 8'h42, write address; the read address is DEV_ID|1 (8'h43).
SYNC_STAGES, 2, synchroniser depth on sioc/siod_i (min 2).
ACK_EN, 1, 1 = drive ACK low in the 9th bit; 0 = leave the 9th bit released (pure SCCB don't-care).

Ports:
clk  in  1  core clock; must be at least 16x the sioc frequency.
reset  in  1  asynchronous, active-high reset.
sioc  in  1  SCCB clock from the master.
siod_i  in  1  SCCB data pin input.
siod_oe  out  1  1 = pull siod low; 0 = release (pad is open-drain, pulled up).
reg_addr  out  8  current register pointer.
wr_en  out  1  one-cycle write strobe.
wr_data  out  8  write data, valid while wr_en=1.
rd_data  in  8  register contents at reg_addr; sampled by the block.
busy  out  1  1 between a detected START and STOP.
id_err  out  1  one-cycle pulse on a device ID mismatch.

Behaviour:
- Reset (async, active-high): siod_oe=0, wr_en=0, id_err=0, busy=0, reg_addr=0, wr_data=0, state=IDLE, synchronisers loaded with 1.
- Sync: sioc and siod_i each pass through SYNC_STAGES flops. Edges are computed from the last two synced samples. Pin-to-event latency is SYNC_STAGES+1 clk.
- START: synced siod falls while synced sioc=1. STOP: synced siod rises while synced sioc=1. Both are valid in any state and override the bit logic in the same cycle.
- START (including repeated START): state=ID, bit count=0, busy=1, siod_oe=0.
- STOP: state=IDLE, busy=0, siod_oe=0. reg_addr is retained.
- Data is sampled on the sioc rising edge, MSB first. siod_oe changes only on the sioc falling edge.
- Byte frame is 9 bits: 8 data bits plus the ACK slot. Bit counter 0..8 wraps to 0.
- States: IDLE, ID, ADDR, WDATA, RDATA, IGNORE.
- IDLE: waits for START; edges otherwise ignored.
- ID, after 8 bits:
  - DEV_ID: ACK, next state ADDR.
  - DEV_ID|1: ACK, next state RDATA.
  - Other value: pulse id_err, no ACK, next state IGNORE.
- ADDR: after 8 bits, reg_addr is loaded 1 clk after the 8th rising edge. ACK, next state WDATA.
- WDATA: after 8 bits:
  - wr_data=byte and wr_en=1 for exactly one clk, 1 clk after the 8th rising edge.
  - ACK.
  - After the ACK, reg_addr increments (8-bit wrap, 0xFF->0x00) and the state stays WDATA, giving sequential writes.
- ACK drive: on the falling edge after the 8th sample, siod_oe=ACK_EN. On the next falling edge, siod_oe=0.
- RDATA:
  - rd_data is latched into the shift register on the falling edge that ends the ID ACK.
  - The same edge drives bit7: siod_oe=~bit. Each subsequent falling edge shifts out the next bit.
  - After bit0's falling edge, siod_oe=0 for the master NA/ACK slot.
  - The master's 9th bit is ignored. reg_addr increments (wrap) and the state goes to IGNORE.
- IGNORE: siod_oe=0 and no strobes until START or STOP.
- A STOP before a byte completes discards the partial byte; no wr_en is issued.
- reset asserted mid-transfer: siod_oe drops in the same instant (async), without waiting for a sioc edge.

Decomposition:
- Shared package/include sccb_pkg:
  - state encoding constants (IDLE..IGNORE);
  - SCCB_BITS_PER_PHASE=9;
  - default OV7670 IDs 8'h42/8'h43, so the init path and the responder share one definition.
- Sub-module sccb_line_sync: synchroniser, sioc rise/fall pulses, START/STOP pulses, synced siod level. It is reusable by the master side.

Test Plan:
- Write 42/12/80 (START, ID, addr 0x12, data 0x80, STOP) -> siod low in all 3 ACK slots. wr_en pulses once with reg_addr=0x12, wr_data=0x80. busy returns to 0 after STOP.
- ID 0x60 followed by 2 bytes, then STOP -> id_err pulse, siod_oe never asserted, no wr_en, state IGNORE until STOP.
- Write 42/0A, STOP, START, 43, rd_data=0x76 -> master samples 0,1,1,1,0,1,1,0; siod released in the 9th slot; reg_addr=0x0B afterwards.
- Sequential write 42/FF/11/22 -> wr_en at (0xFF,0x11) then (0x00,0x22).
- Repeated START after 42/05 with no STOP, then 42/06/33 -> single wr_en at (0x06,0x33). STOP after 42/05 alone -> no wr_en, reg_addr=0x05.
- Assert reset while siod_oe=1 during an ACK -> siod_oe=0 and busy=0 immediately. After release, a new 42/01/55 write completes normally.
